// File: rtl/fx2_pkg.sv
// fx2_pkg: FIFOADR endpoint codes and default bus width for the FX2 slave-FIFO model.
package fx2_pkg;
  localparam logic [1:0] EP2 = 2'b00;
  localparam logic [1:0] EP4 = 2'b01;
  localparam logic [1:0] EP6 = 2'b10;
  localparam logic [1:0] EP8 = 2'b11;
  localparam int DW_DEF = 16;
endpackage

// File: rtl/fx2_ep_fifo.sv
// fx2_ep_fifo: single-clock first-word-fall-through endpoint FIFO with level/full/empty.
module fx2_ep_fifo
  import fx2_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty
);
  localparam int DEPTH = 1 << AW;
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] level_q, level_d;
  logic do_push, do_pop;
  assign empty = level_q == '0;
  assign full = level_q == (AW+1)'(DEPTH);
  assign level = level_q;
  assign head = mem[rd_q];
  // push/pop gated by pre-edge level only, so a full FIFO refuses a push even when popped
  always_comb begin
    do_push = push && !full;
    do_pop = pop && !empty;
    wr_d = wr_q + AW'(do_push);
    rd_d = rd_q + AW'(do_pop);
    level_d = level_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      level_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      level_q <= level_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q] <= push_data;
  end
endmodule

// File: rtl/fx2_slave_fifo_model.sv
// fx2_slave_fifo_model: FX2 slave-FIFO responder with EP2 (OUT) and EP6 (IN) endpoints,
// strobe decode, FDATA tristate, flags and sticky protocol error detection.
module fx2_slave_fifo_model
  import fx2_pkg::*;
#(
  parameter int         DW = DW_DEF,
  parameter int         DEPTH_LOG2 = 9,
  parameter logic [1:0] EP2_ADDR = EP2,
  parameter logic [1:0] EP6_ADDR = EP6
) (
  input  logic                IFCLK,
  input  logic                rst,
  input  logic                SLWR,
  input  logic                SLRD,
  input  logic                SLOE,
  input  logic [1:0]          FIFOADR,
  inout  wire  [DW-1:0]       FDATA,
  output logic                FLAGA,
  output logic                FLAGD,
  input  logic                host_out_valid,
  input  logic [DW-1:0]       host_out_data,
  output logic                host_out_ready,
  output logic                host_in_valid,
  output logic [DW-1:0]       host_in_data,
  input  logic                host_in_ready,
  output logic [DEPTH_LOG2:0] ep2_level,
  output logic [DEPTH_LOG2:0] ep6_level,
  output logic                err_underrun,
  output logic                err_overrun,
  output logic                err_contention
);
  logic rd_req, wr_req, rd_fire, oe;
  logic ep2_full, ep2_empty, ep6_full, ep6_empty;
  logic [DW-1:0] ep2_head, last_q, last_d;
  logic err_underrun_q, err_underrun_d, err_overrun_q, err_overrun_d;
  logic err_contention_q, err_contention_d;
  fx2_ep_fifo #(.DW(DW), .AW(DEPTH_LOG2)) u_ep2 (
    .clk(IFCLK), .rst(rst), .push(host_out_valid), .push_data(host_out_data),
    .pop(rd_req), .head(ep2_head), .level(ep2_level), .full(ep2_full), .empty(ep2_empty)
  );
  fx2_ep_fifo #(.DW(DW), .AW(DEPTH_LOG2)) u_ep6 (
    .clk(IFCLK), .rst(rst), .push(wr_req), .push_data(FDATA),
    .pop(host_in_ready), .head(host_in_data), .level(ep6_level), .full(ep6_full),
    .empty(ep6_empty)
  );
  assign oe = !SLOE && FIFOADR == EP2_ADDR;
  // an empty EP2 keeps showing the word most recently read out
  assign FDATA = oe ? (ep2_empty ? last_q : ep2_head) : 'z;
  assign FLAGA = !ep2_empty;
  assign FLAGD = !ep6_full;
  assign host_out_ready = !ep2_full;
  assign host_in_valid = !ep6_empty;
  assign err_underrun = err_underrun_q;
  assign err_overrun = err_overrun_q;
  assign err_contention = err_contention_q;
  always_comb begin
    rd_req = !SLRD && FIFOADR == EP2_ADDR;
    wr_req = !SLWR && FIFOADR == EP6_ADDR;
    rd_fire = rd_req && !ep2_empty;
    last_d = rd_fire ? ep2_head : last_q;
    err_underrun_d = err_underrun_q || (rd_req && ep2_empty);
    err_overrun_d = err_overrun_q || (wr_req && ep6_full);
    err_contention_d = err_contention_q || (!SLOE && !SLWR);
  end
  always_ff @(posedge IFCLK or posedge rst) begin
    if (rst) begin
      last_q <= '0;
      err_underrun_q <= 1'b0;
      err_overrun_q <= 1'b0;
      err_contention_q <= 1'b0;
    end else begin
      last_q <= last_d;
      err_underrun_q <= err_underrun_d;
      err_overrun_q <= err_overrun_d;
      err_contention_q <= err_contention_d;
    end
  end
endmodule

// File: tb/tb_fx2_slave_fifo_model.sv
// tb_fx2_slave_fifo_model: directed plus randomized checks against a queue-based endpoint model.
module tb_fx2_slave_fifo_model;
  logic IFCLK = 1'b0, rst = 1'b1;
  logic SLWR = 1'b1, SLRD = 1'b1, SLOE = 1'b1;
  logic [1:0] FIFOADR = 2'b01;
  wire [15:0] FDATA;
  logic tb_oe = 1'b0;
  logic [15:0] tb_d = '0;
  logic FLAGA, FLAGD, host_out_valid = 1'b0, host_out_ready, host_in_valid, host_in_ready = 1'b0;
  logic [15:0] host_out_data = '0, host_in_data;
  logic [9:0] ep2_level, ep6_level;
  logic err_underrun, err_overrun, err_contention;
  int n_cmp = 0, n_fail = 0;
  logic [15:0] q2[$], q6[$];
  logic [15:0] m_last = '0;
  bit m_eu = 0, m_eo = 0, m_ec = 0;

  assign FDATA = tb_oe ? tb_d : 'z;
  always #5 IFCLK = ~IFCLK;

  fx2_slave_fifo_model dut (
    .IFCLK(IFCLK), .rst(rst), .SLWR(SLWR), .SLRD(SLRD), .SLOE(SLOE), .FIFOADR(FIFOADR),
    .FDATA(FDATA), .FLAGA(FLAGA), .FLAGD(FLAGD), .host_out_valid(host_out_valid),
    .host_out_data(host_out_data), .host_out_ready(host_out_ready),
    .host_in_valid(host_in_valid), .host_in_data(host_in_data),
    .host_in_ready(host_in_ready), .ep2_level(ep2_level), .ep6_level(ep6_level),
    .err_underrun(err_underrun), .err_overrun(err_overrun), .err_contention(err_contention)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q2.delete();
    q6.delete();
    m_last = '0;
    m_eu = 0;
    m_eo = 0;
    m_ec = 0;
  endtask

  // one clock edge: the model applies the endpoint rules to the pre-edge inputs
  task automatic tick();
    bit rd, wr;
    int s2, s6;
    rd = !SLRD && FIFOADR == 2'b00;
    wr = !SLWR && FIFOADR == 2'b10;
    s2 = q2.size();
    s6 = q6.size();
    if (rd && s2 == 0) m_eu = 1;
    if (wr && s6 == 512) m_eo = 1;
    if (!SLOE && !SLWR) m_ec = 1;
    if (rd && s2 > 0) m_last = q2.pop_front();
    if (host_out_valid && s2 < 512) q2.push_back(host_out_data);
    if (host_in_ready && s6 > 0) void'(q6.pop_front());
    if (wr && s6 < 512) q6.push_back(tb_d);
    @(posedge IFCLK);
    #1;
  endtask

  task automatic check();
    chk("ep2_level", 32'(ep2_level), 32'(q2.size()));
    chk("ep6_level", 32'(ep6_level), 32'(q6.size()));
    chk("FLAGA", 32'(FLAGA), 32'(q2.size() != 0));
    chk("FLAGD", 32'(FLAGD), 32'(q6.size() != 512));
    chk("host_out_ready", 32'(host_out_ready), 32'(q2.size() != 512));
    chk("host_in_valid", 32'(host_in_valid), 32'(q6.size() != 0));
    if (q6.size() != 0) chk("host_in_data", 32'(host_in_data), 32'(q6[0]));
    if (!SLOE && FIFOADR == 2'b00)
      chk("FDATA", 32'(FDATA), 32'(q2.size() != 0 ? q2[0] : m_last));
    chk("err_underrun", 32'(err_underrun), 32'(m_eu));
    chk("err_overrun", 32'(err_overrun), 32'(m_eo));
    chk("err_contention", 32'(err_contention), 32'(m_ec));
  endtask

  initial begin
    repeat (2) @(posedge IFCLK);
    #1;
    rst = 1'b0;
    check();
    // host loads 1..4, then the bus must stay free while SLOE is high
    host_out_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      host_out_data = 16'(i);
      tick();
      check();
    end
    host_out_valid = 1'b0;
    FIFOADR = 2'b00;
    tb_oe = 1'b1;
    tb_d = 16'hA5A5;
    #1 chk("bus_free_a5", 32'(FDATA), 32'h0000A5A5);
    tb_d = 16'h5A5A;
    #1 chk("bus_free_5a", 32'(FDATA), 32'h00005A5A);
    tb_oe = 1'b0;
    SLOE = 1'b0;
    #1 chk("fwft_head", 32'(FDATA), 32'h1);
    SLRD = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) chk("read_seq", 32'(FDATA), 32'(i));
      tick();
      check();
    end
    chk("underrun_set", 32'(err_underrun), 32'h1);
    SLRD = 1'b1;
    SLOE = 1'b1;
    // master fills EP6 to capacity, then overruns it once
    FIFOADR = 2'b10;
    tb_oe = 1'b1;
    SLWR = 1'b0;
    for (int i = 0; i < 513; i++) begin
      tb_d = (i == 512) ? 16'hDEAD : 16'(i);
      tick();
      check();
    end
    chk("flagd_full", 32'(FLAGD), 32'h0);
    chk("overrun_set", 32'(err_overrun), 32'h1);
    SLWR = 1'b1;
    host_in_ready = 1'b1;
    for (int i = 0; i < 512; i++) begin
      chk("drain_order", 32'(host_in_data), 32'(i));
      tick();
      check();
    end
    host_in_ready = 1'b0;
    // contention: SLOE and SLWR low together on EP6, the write still lands
    SLOE = 1'b0;
    SLWR = 1'b0;
    tb_d = 16'hC0DE;
    tick();
    check();
    chk("contention_word", 32'(host_in_data), 32'h0000C0DE);
    SLOE = 1'b1;
    SLWR = 1'b1;
    host_in_ready = 1'b1;
    tick();
    host_in_ready = 1'b0;
    // EP2 held at level 3 with simultaneous push and read across pointer wrap
    tb_oe = 1'b0;
    FIFOADR = 2'b00;
    host_out_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      host_out_data = 16'($urandom);
      tick();
    end
    check();
    SLOE = 1'b0;
    SLRD = 1'b0;
    for (int i = 0; i < 600; i++) begin
      host_out_data = 16'($urandom);
      tick();
      check();
    end
    chk("wrap_level", 32'(ep2_level), 32'h3);
    // randomized mix of strobes and host traffic
    for (int i = 0; i < 400; i++) begin
      SLRD = 1'($urandom);
      SLWR = 1'($urandom);
      SLOE = 1'($urandom);
      FIFOADR = 2'($urandom);
      host_out_valid = 1'($urandom);
      host_out_data = 16'($urandom);
      host_in_ready = ($urandom_range(3) == 0);
      tb_d = 16'($urandom);
      tb_oe = !(!SLOE && FIFOADR == 2'b00);
      tick();
      check();
    end
    // asynchronous reset in the middle of a write burst
    SLOE = 1'b1;
    SLRD = 1'b1;
    SLWR = 1'b0;
    FIFOADR = 2'b10;
    tb_oe = 1'b1;
    host_in_ready = 1'b0;
    host_out_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tb_d = 16'($urandom);
      tick();
    end
    check();
    #2 rst = 1'b1;
    #1;
    chk("async_ep2_level", 32'(ep2_level), 32'h0);
    chk("async_ep6_level", 32'(ep6_level), 32'h0);
    chk("async_flaga", 32'(FLAGA), 32'h0);
    chk("async_flagd", 32'(FLAGD), 32'h1);
    chk("async_err_contention", 32'(err_contention), 32'h0);
    model_reset();
    SLWR = 1'b1;
    host_out_valid = 1'b0;
    @(posedge IFCLK);
    #1 rst = 1'b0;
    check();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/fx2_slave_fifo_model.md
Name: fx2_slave_fifo_model

Overview:
- Synthesizable responder for the FX2 slave-FIFO interface: the device side that the FPGA `usb` master talks to. Clocked by the master's IFCLK.
- Provides two endpoint FIFOs:
  - EP2 (OUT, host→FPGA), read by the master with SLRD/SLOE.
  - EP6 (IN, FPGA→host), written by the master with SLWR.
- Generates FLAGA and FLAGD from the FIFO levels.
- A host-side stream port loads EP2 and drains EP6. Used for loopback benches and on-board self-test in place of the real chip.

Parameters:
- DW, 16, FDATA / FIFO word width.
- DEPTH_LOG2, 9, log2 of words per endpoint FIFO (512).
- EP2_ADDR, 2'b00, FIFOADR value that selects EP2.
- EP6_ADDR, 2'b10, FIFOADR value that selects EP6.

Ports:
- IFCLK  in  1  interface clock, all state on the rising edge.
- rst  in  1  asynchronous active-high reset.
- SLWR  in  1  active-low write strobe from the master.
- SLRD  in  1  active-low read strobe from the master.
- SLOE  in  1  active-low output enable for FDATA.
- FIFOADR  in  2  endpoint select.
- FDATA  inout  DW  bidirectional data bus.
- FLAGA  out  1  EP2 empty flag, active-low (0 = empty).
- FLAGD  out  1  EP6 full flag, active-low (0 = full).
- host_out_valid  in  1  host pushes a word into EP2.
- host_out_data  in  DW  word to push.
- host_out_ready  out  1  EP2 not full.
- host_in_valid  out  1  EP6 not empty.
- host_in_data  out  DW  EP6 head word, first-word-fall-through.
- host_in_ready  in  1  host pops EP6.
- ep2_level  out  DEPTH_LOG2+1  EP2 occupancy.
- ep6_level  out  DEPTH_LOG2+1  EP6 occupancy.
- err_underrun  out  1  sticky: read attempted on empty EP2.
- err_overrun  out  1  sticky: write attempted on full EP6.
- err_contention  out  1  sticky: SLOE and SLWR both low in the same cycle.

Behaviour:
- Reset (async, rst=1):
  - Both FIFOs are emptied; levels = 0.
  - FLAGA=0, FLAGD=1, host_out_ready=1, host_in_valid=0.
  - All err_* = 0; FDATA is high-Z.
  - Reset asserted mid-transfer discards all contents immediately.
- FDATA drive:
  - Driven with the EP2 head word when SLOE=0 and FIFOADR=EP2_ADDR. Combinational from the registered head, first-word-fall-through.
  - High-Z otherwise.
  - If EP2 is empty while driven, the last-read word is held (0 after reset).
- Read: on the IFCLK edge with SLRD=0, FIFOADR=EP2_ADDR and EP2 not empty:
  - EP2 pops.
  - The next word appears on FDATA after that edge.
- Read with SLRD=0, FIFOADR=EP2_ADDR and EP2 empty: no pop; err_underrun set.
- Write: on the IFCLK edge with SLWR=0, FIFOADR=EP6_ADDR and EP6 not full:
  - FDATA is sampled and pushed into EP6.
  - Word becomes visible on host_in_data after that edge.
- Write with SLWR=0, FIFOADR=EP6_ADDR and EP6 full: word dropped; err_overrun set.
- Strobes with any other FIFOADR (EP4/EP8, or a mismatched endpoint) are ignored, with no error.
- SLOE=0 and SLWR=0 in the same cycle: err_contention set. The write still proceeds if its own conditions hold.
- Flags:
  - FLAGA = (ep2_level != 0); FLAGD = (ep6_level != DEPTH).
  - Both are combinational from the registered levels, so they update in the same cycle the level changes. No extra flag latency.
- Host side:
  - EP2 pushes when host_out_valid & host_out_ready.
  - EP6 pops when host_in_valid & host_in_ready.
- Simultaneous push and pop on the same FIFO:
  - Both occur and the level is unchanged.
  - On an empty FIFO, the pop is refused (no bypass). The pushed word is poppable next cycle.
  - On a full FIFO with a pop, the push is accepted only if the FIFO's ready is based on the pre-edge level, i.e. refused. Ready/flags never look ahead.
- Pointers:
  - DEPTH_LOG2-bit pointers, wrap modulo DEPTH.
  - Level is DEPTH_LOG2+1 bits, 0..DEPTH inclusive.
- Sticky errors clear only on rst.

Decomposition:
- Package fx2_pkg holds:
  - FIFOADR constants EP2/EP4/EP6/EP8 = 00/01/10/11.
  - Default DW.
- One sub-module, fx2_ep_fifo:
  - Single-clock FWFT FIFO with push/pop, level, full, empty.
  - Instantiated twice: EP2 and EP6.
- Top level contains the strobe decode, tristate, flag and error logic.

Test Plan:
- Reset release with no stimulus → FLAGA=0, FLAGD=1, FDATA=Z, both levels 0, all err_* 0.
- Host pushes 0x0001..0x0004 into EP2. Master holds SLOE=0, SLRD=0, FIFOADR=00 for 4 cycles → FDATA sequence 0x0001..0x0004, ep2_level 4→0, FLAGA falls after the 4th pop, err_underrun=0.
- A 5th SLRD pulse on empty EP2 → no pop, err_underrun=1, ep2_level stays 0.
- Master writes 512 words (0x0000..0x01FF) with SLWR=0, FIFOADR=10 → FLAGD=0 after word 512. A 513th write sets err_overrun and ep6_level stays 512. Host drain returns 0x0000..0x01FF in order.
- EP2 level 3, host push and master SLRD in the same cycle → ep2_level stays 3, FIFO order preserved. Repeated over 600 words to exercise pointer wrap.
- SLOE=0 and SLWR=0 with FIFOADR=10 → err_contention=1 and the word is still written. Asserting rst mid-burst → levels 0 and FLAGA=0 immediately, without waiting for a clock edge.
